uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit-side counterpart of the UART receive path. Accepts one byte per handshake and serialises it onto the line as an 8N1 frame: start bit 0, eight data bits LSB first, stop bit 1. Every bit is held for exactly CLOCKS_PER_BIT system clocks. It sits between the byte-producing logic and the Tx pin, using the same bit timing as the Rx sampling logic so both ends agree on baud.

## Interface
- CLOCKS_PER_BIT, 5000 (8 under FORMAL): system clocks per UART bit (48 MHz / 9600 Hz); must be ≥ 2.
- clk  input  1  system clock (48 MHz); all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  block is idle and can accept a byte.
- tx_serial  output  1  UART line, idle high; registered output.
- tx_busy  output  1  a frame is in progress (start, data or stop bit).

## Operation
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready. tx_data is latched into a shift register at that edge; later changes on tx_data are ignored.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_serial = 1, tx_ready = 1, tx_busy = 0.
  - On handshake, go to START and clear the bit timer.
- START: tx_serial = 0 for CLOCKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_serial = shift_reg[0].
  - On each bit-timer wrap, shift right and increment the bit index.
  - After bit index 7 wraps, go to STOP.
- STOP: tx_serial = 1 for CLOCKS_PER_BIT cycles, then go to IDLE.
- tx_ready = 1 only in IDLE. tx_busy = 1 in START, DATA and STOP.
- Bit timer:
  - Counter width $clog2(CLOCKS_PER_BIT); counts 0..CLOCKS_PER_BIT-1.
  - Produces a single-cycle bit_done pulse when count == CLOCKS_PER_BIT-1, then wraps to 0.
  - Cleared on handshake. Held at 0 in IDLE.
- Bit index: 3 bits, no wrap beyond 7. The DATA→STOP transition is taken at index 7 with bit_done.
- tx_valid asserted outside IDLE is not a handshake. The producer holds it until tx_ready.

## Timing
- Reset values: tx_serial = 1, tx_ready = 1, tx_busy = 0, state = IDLE, counter = 0, bit index = 0, shift_reg = 0.
- Latency: handshake at edge N puts tx_serial at 0 from edge N+1 onward.
- Frame length: exactly 10 × CLOCKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Bit k (k = 0..7) occupies cycles N+1+(k+1)·CPB through N+(k+2)·CPB.
- STOP→IDLE is taken at the edge after the final stop cycle, and tx_ready rises at that edge.
- Back-to-back frames with tx_valid held high: one idle-high cycle between frames, so the frame period is 10·CPB + 1 cycles.
- Reset mid-frame: tx_serial goes to 1 and tx_ready to 1 immediately (asynchronous). The in-flight byte is discarded, with no partial stop bit.
- Reset released while tx_valid = 1: no acceptance until the first rising edge after deassertion.
- bit_done never pulses in two consecutive cycles.
- tx_serial is glitch-free (flop output) and changes only on bit boundaries.

## Structure
- Shared UART package (shared with the Rx side):
  - DATA_BITS = 8
  - FSM state encoding (IDLE/START/DATA/STOP, 2-bit)
  - CLOCKS_PER_BIT defaults (5000 normal, 8 formal)
- Sub-module tx_bit_timer: counter plus bit_done generation. Inputs clk, reset, clear, enable; output bit_done; parameter CLOCKS_PER_BIT.
- Top level holds the FSM, shift register, bit index and output flops.
- FORMAL properties:
  - tx_serial == 1 whenever tx_ready.
  - !(tx_ready && tx_busy).
  - bit_done is single-pulse.
  - The start bit lasts exactly CPB cycles.

## Test plan
All scenarios use CLOCKS_PER_BIT = 8.
- Reset asserted, then released with no traffic → tx_serial = 1, tx_ready = 1, tx_busy = 0 for 100 cycles.
- Send 0x55 → line 0,1,0,1,0,1,0,1,0,1, each level 8 cycles. tx_ready low for 80 cycles, high on cycle 81.
- Send 0xA3 with tx_valid held high and tx_data changed to 0xFF one cycle after the handshake → serial bits 1,1,0,0,0,1,0,1 (LSB first), proving the byte was latched.
- Back-to-back 0x00 then 0xFF → exactly one high idle cycle between the first stop bit and the second start bit. Total 161 cycles.
- Reset pulsed during data bit 3 of 0x0F → tx_serial = 1 in the same cycle, tx_ready = 1, no further low bits. A following 0x81 transmits correctly.
- Loopback into the Rx path for 256 random bytes → every received byte matches the sent byte, with no framing errors.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// rtl/uart_tx_serializer_pkg.sv - shared UART constants and FSM state encoding
package uart_tx_serializer_pkg;

  localparam int DATA_BITS  = 8;
  localparam int CPB_NORMAL = 5000;
  localparam int CPB_FORMAL = 8;

`ifdef FORMAL
  localparam int CPB_DEFAULT = CPB_FORMAL;
`else
  localparam int CPB_DEFAULT = CPB_NORMAL;
`endif

  // Index of the last data bit; the DATA->STOP move happens when this bit's timer wraps.
  localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - per-bit cycle counter producing a one-cycle bit_done strobe
module tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int            CW   = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: held at zero while idle or on a new handshake, otherwise 0..CPB-1 and wrap.
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The counter always returns to zero after LAST, so this strobe cannot repeat back to back.
  assign bit_done = enable && (count_q == LAST);

`ifdef FORMAL
  logic bit_done_prev_q;

  // Single-pulse property on bit_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_done_prev_q <= 1'b0;
    end else begin
      bit_done_prev_q <= bit_done;
      assert (!(bit_done && bit_done_prev_q));
    end
  end
`endif

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter with valid/ready byte intake
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CPB_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_serial_q, tx_serial_d;
  logic        tx_ready_q, tx_ready_d;
  logic        tx_busy_q, tx_busy_d;

  logic        handshake;
  logic        bit_done;

  // tx_ready_q is high exactly in IDLE, so it doubles as the acceptance qualifier.
  assign handshake = tx_valid && tx_ready_q;

  tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (handshake),
    .enable  (state_q != ST_IDLE),
    .bit_done(bit_done)
  );

  // Next-state, shift register, bit index, and line/handshake outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_START;
          shift_d = tx_data;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == LAST_BIT_IDX) begin
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next state so the flops present them in the same cycle the state is entered.
    tx_serial_d = 1'b1;
    tx_ready_d  = 1'b0;
    tx_busy_d   = 1'b1;
    case (state_d)
      ST_IDLE: begin
        tx_ready_d = 1'b1;
        tx_busy_d  = 1'b0;
      end
      ST_START: tx_serial_d = 1'b0;
      ST_DATA:  tx_serial_d = shift_d[0];
      ST_STOP:  tx_serial_d = 1'b1;
      default:  tx_serial_d = 1'b1;
    endcase
  end

  // FSM and output registers; reset forces an idle-high line immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      idx_q       <= 3'd0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      tx_serial_q <= tx_serial_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;

`ifdef FORMAL
  // Idle line must be high and ready/busy are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (tx_ready_q) assert (tx_serial_q);
      assert (!(tx_ready_q && tx_busy_q));
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after the handshake edge. Samples every cycle of the 10-bit frame at negedge,
  // compares against the ideal waveform and decodes the byte at bit centres like a receiver would.
  task automatic check_frame(input logic [7:0] d, input bit alter, input bit drop_valid,
                             output int t_first, output int t_last);
    logic [9:0] frame;
    logic [7:0] rx;
    logic       start_bit;
    logic       stop_bit;
    int         errs;
    int         b;
    frame     = {1'b1, d, 1'b0};
    rx        = 8'h00;
    start_bit = 1'bx;
    stop_bit  = 1'bx;
    errs      = 0;
    t_first   = 0;
    for (int j = 1; j <= 10 * CPB; j++) begin
      @(negedge clk);
      if (j == 1) t_first = cyc;
      b = (j - 1) / CPB;
      if (tx_serial !== frame[b] || tx_ready !== 1'b0 || tx_busy !== 1'b1) errs++;
      if ((j - 1) % CPB == CPB / 2) begin
        if (b == 0) start_bit = tx_serial;
        else if (b == 9) stop_bit = tx_serial;
        else rx[b-1] = tx_serial;
      end
      if (j == 1) begin
        if (alter) tx_data = 8'hFF;
        if (drop_valid) tx_valid = 1'b0;
      end
    end
    chk("frame_waveform_errs", 32'(errs), 32'd0);
    chk("rx_byte", 32'(rx), 32'(d));
    chk("rx_framing", 32'({start_bit, stop_bit}), 32'd1);
    @(negedge clk);
    t_last = cyc;
    chk("post_frame_idle", 32'({tx_ready, tx_serial, tx_busy}), 32'b110);
  endtask

  // Waits (bounded) for tx_ready at negedges, presents the byte, then checks the frame.
  task automatic send(input logic [7:0] d, input bit alter, input bit drop_valid,
                      output int waited, output int t_first, output int t_last);
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) chk("ready_timeout", 32'(waited), 32'd0);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    check_frame(d, alter, drop_valid, t_first, t_last);
  endtask

  initial begin
    int         errs;
    int         w, w2, t0, t1, tf, tl;
    logic [7:0] d;
    bit         hold, prev_hold;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({tx_ready, tx_serial, tx_busy}), 32'b110);

    // Idle after reset with no traffic.
    reset = 1'b0;
    errs  = 0;
    repeat (100) begin
      @(negedge clk);
      if ({tx_ready, tx_serial, tx_busy} !== 3'b110) errs++;
    end
    chk("idle_100_cycles", 32'(errs), 32'd0);

    // Single frame, valid dropped after handshake.
    send(8'h55, 1'b0, 1'b1, w, tf, tl);
    chk("frame_0x55_len", 32'(tl - tf), 32'd80);

    // Data changed after handshake while valid held; the latched byte must go out.
    send(8'hA3, 1'b1, 1'b0, w, tf, tl);
    tx_valid = 1'b0;

    // Back-to-back frames with valid held high.
    send(8'h00, 1'b0, 1'b0, w, t0, tl);
    send(8'hFF, 1'b0, 1'b1, w2, tf, t1);
    chk("b2b_idle_gap_wait", 32'(w2), 32'd0);
    chk("b2b_total_cycles", 32'(t1 - t0), 32'd161);

    // Reset pulsed during data bit 3 of 0x0F; valid held during reset must not be accepted early.
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 35; j++) begin
      @(negedge clk);
      if (j == 1) tx_valid = 1'b0;
    end
    chk("pre_reset_busy", 32'({tx_ready, tx_busy}), 32'b01);
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    #1;
    chk("async_reset_outputs", 32'({tx_ready, tx_serial, tx_busy}), 32'b110);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if ({tx_ready, tx_serial, tx_busy} !== 3'b110) errs++;
    end
    chk("held_reset_idle", 32'(errs), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    check_frame(8'h81, 1'b0, 1'b1, tf, tl);

    // Random bytes with random gaps, decoded by the bench's receiver model.
    prev_hold = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d    = 8'($urandom);
      hold = (i != 255) && ($urandom_range(0, 1) == 0);
      send(d, 1'b0, !hold, w, tf, tl);
      if (prev_hold) chk("rand_b2b_wait", 32'(w), 32'd0);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      prev_hold = hold;
    end
    tx_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
